// File: rtl/multdiv_pkg.sv
// Shared encodings and default timing constants for the multiply/divide sequencer.
package multdiv_pkg;

    // Width of the wait counter; must hold DEF_TIMEOUT.
    localparam int CNT_W       = 6;
    // Cycles after the start pulse before a unit ready level is trusted.
    localparam int DEF_MIN_LAT = 2;
    // BUSY cycles without a trusted ready before a forced exception completion.
    localparam int DEF_TIMEOUT = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    // Multiply has priority when both request lines are high.
    function automatic op_t decode_op(input logic is_mult);
        return is_mult ? OP_MULT : OP_DIV;
    endfunction

endpackage

// File: rtl/multdiv_wait_timer.sv
// Wait counter for the BUSY phase: cleared while the start pulse is out,
// counts BUSY cycles, and flags when unit ready may be trusted or the
// operation has overrun.
module multdiv_wait_timer
    import multdiv_pkg::*;
#(
    parameter int MIN_LAT = DEF_MIN_LAT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic ge_min,
    output logic hit_timeout
);

    localparam logic [CNT_W-1:0] MIN_LAT_C = CNT_W'(MIN_LAT);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [CNT_W-1:0] count_reg;

    // Count enabled cycles; saturate rather than wrap so a stuck enable cannot alias back under MIN_LAT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign ge_min      = (count_reg >= MIN_LAT_C);
    assign hit_timeout = (count_reg >= TIMEOUT_C);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing front-end between the pipeline's multiply/divide requests and the
// iterative mult/div units: latches operands, fires a one-cycle start pulse,
// waits for a trusted ready (or times out), registers the result and strobes
// data_resultRDY for one cycle.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MIN_LAT = DEF_MIN_LAT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             mult_start,
    output logic             div_start,
    input  logic [WIDTH-1:0] mult_result,
    input  logic             mult_ready,
    input  logic             mult_ovf,
    input  logic [WIDTH-1:0] div_quot,
    input  logic             div_ready,
    input  logic             div_div0
);

    state_t           state_reg, state_next;
    op_t              op_reg, op_next;
    logic [WIDTH-1:0] op_a_reg, op_a_next;
    logic [WIDTH-1:0] op_b_reg, op_b_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             exc_reg, exc_next;
    logic             mult_start_reg, mult_start_next;
    logic             div_start_reg, div_start_next;

    logic             req;
    logic             unit_ready;
    logic             timer_clr;
    logic             timer_en;
    logic             ge_min;
    logic             hit_timeout;

    assign req        = ctrl_MULT | ctrl_DIV;
    assign unit_ready = (op_reg == OP_MULT) ? mult_ready : div_ready;

    // The counter is held at zero for the whole START cycle, so the first BUSY cycle sees 0.
    assign timer_clr  = (state_reg == START);
    assign timer_en   = (state_reg == BUSY);

    multdiv_wait_timer #(
        .MIN_LAT (MIN_LAT),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (timer_clr),
        .en          (timer_en),
        .ge_min      (ge_min),
        .hit_timeout (hit_timeout)
    );

    // Next-state, operand latch, result capture and start-pulse generation.
    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        op_a_next       = op_a_reg;
        op_b_next       = op_b_reg;
        result_next     = result_reg;
        exc_next        = exc_reg;
        mult_start_next = 1'b0;
        div_start_next  = 1'b0;

        if (req) begin
            // A new request always wins: it starts from IDLE, aborts an op in
            // START/BUSY, or queues behind the strobe when it lands in DONE.
            state_next = START;
            op_next    = decode_op(ctrl_MULT);
            op_a_next  = data_operandA;
            op_b_next  = data_operandB;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = IDLE;
                end
                START: begin
                    state_next = BUSY;
                end
                BUSY: begin
                    // A trusted ready beats the timeout if both occur on the same edge.
                    if (unit_ready && ge_min) begin
                        state_next = DONE;
                        if (op_reg == OP_MULT) begin
                            result_next = mult_result;
                            exc_next    = mult_ovf;
                        end else begin
                            result_next = div_quot;
                            exc_next    = div_div0;
                        end
                    end else if (hit_timeout) begin
                        state_next  = DONE;
                        result_next = '0;
                        exc_next    = 1'b1;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Pulse the selected unit when entering START. A request landing in the
        // START cycle itself re-enters START; that unit was cleared one cycle
        // earlier and reads op_a/op_b live, so its pulse is not stretched.
        mult_start_next = (state_next == START) && (op_next == OP_MULT) && !mult_start_reg;
        div_start_next  = (state_next == START) && (op_next == OP_DIV)  && !div_start_reg;
    end

    // State, operand, result and start-pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            op_reg         <= OP_MULT;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            result_reg     <= '0;
            exc_reg        <= 1'b0;
            mult_start_reg <= 1'b0;
            div_start_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            op_a_reg       <= op_a_next;
            op_b_reg       <= op_b_next;
            result_reg     <= result_next;
            exc_reg        <= exc_next;
            mult_start_reg <= mult_start_next;
            div_start_reg  <= div_start_next;
        end
    end

    assign data_result    = result_reg;
    assign data_exception = exc_reg;
    assign data_resultRDY = (state_reg == DONE);
    assign busy           = (state_reg == START) || (state_reg == BUSY);
    assign op_a           = op_a_reg;
    assign op_b           = op_b_reg;
    assign mult_start     = mult_start_reg;
    assign div_start      = div_start_reg;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed vector table, hand-written
// abort / DONE-request / priority / reset sequences, and randomized ops checked
// against a cycle-timeline reference model.
module tb_multdiv_ctrl;

    localparam int WIDTH   = 32;
    localparam int MIN_LAT = 2;
    localparam int TIMEOUT = 40;
    localparam int MAX_CYC = 48;

    logic             clk;
    logic             reset_n;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] mult_result;
    logic             mult_ready;
    logic             mult_ovf;
    logic [WIDTH-1:0] div_quot;
    logic             div_ready;
    logic             div_div0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    multdiv_ctrl #(
        .WIDTH   (WIDTH),
        .MIN_LAT (MIN_LAT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .op_a           (op_a),
        .op_b           (op_b),
        .mult_start     (mult_start),
        .div_start      (div_start),
        .mult_result    (mult_result),
        .mult_ready     (mult_ready),
        .mult_ovf       (mult_ovf),
        .div_quot       (div_quot),
        .div_ready      (div_ready),
        .div_div0       (div_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One operation: stimulus for the unit stub plus expected outputs.
    // stale: ready held high for cycles 0..stale after the start pulse.
    // d: ready high from cycle d onward (99 = never).
    typedef struct {
        bit          is_mult;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ures;
        bit          uflag;
        int          stale;
        int          d;
        logic [31:0] exp_res;
        bit          exp_exc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference timeline: BUSY counter value c is visible in cycle c+1 after the
    // start pulse; a ready level counts only once c >= MIN_LAT, and the strobe
    // follows one cycle later. Without one, the op is forced out at c == TIMEOUT.
    function automatic int model_strobe(input int stale, input int d, output bit timed_out);
        int lat;
        bit found;
        found = 1'b0;
        lat   = TIMEOUT + 2;
        for (int c = MIN_LAT; c < TIMEOUT; c++) begin
            if (!found && (((c + 1) <= stale) || ((c + 1) >= d))) begin
                found = 1'b1;
                lat   = c + 2;
            end
        end
        timed_out = !found;
        return lat;
    endfunction

    // Present a request for one cycle; returns one time unit into the START cycle.
    task automatic issue(input bit m, input bit dv, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = dv;
        data_operandA = a;
        data_operandB = b;
        @(posedge clk);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Drive the selected unit stub (other unit gets random noise) and observe
    // strobes and start pulses, cycle 0 being the START cycle.
    task automatic run_unit(input bit sel_mult, input logic [31:0] ures, input bit uflag,
                            input int stale, input int d,
                            output int first_rdy, output int rdy_cnt,
                            output int ms_cnt, output int ds_cnt,
                            output logic [31:0] res_at, output logic exc_at,
                            output logic busy0, output logic [31:0] opa0, output logic [31:0] opb0);
        bit rdy;
        first_rdy = -1;
        rdy_cnt   = 0;
        ms_cnt    = 0;
        ds_cnt    = 0;
        res_at    = 'x;
        exc_at    = 1'bx;
        busy0     = 1'bx;
        opa0      = 'x;
        opb0      = 'x;
        for (int i = 0; i < MAX_CYC; i++) begin
            rdy = (i <= stale) || (i >= d);
            if (sel_mult) begin
                mult_ready  = rdy;
                mult_result = ures;
                mult_ovf    = uflag;
                div_ready   = 1'($urandom_range(0, 1));
                div_quot    = $urandom;
                div_div0    = 1'($urandom_range(0, 1));
            end else begin
                div_ready   = rdy;
                div_quot    = ures;
                div_div0    = uflag;
                mult_ready  = 1'($urandom_range(0, 1));
                mult_result = $urandom;
                mult_ovf    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (i == 0) begin
                busy0 = busy;
                opa0  = op_a;
                opb0  = op_b;
            end
            if (mult_start) ms_cnt++;
            if (div_start) ds_cnt++;
            if (data_resultRDY) begin
                rdy_cnt++;
                if (first_rdy < 0) begin
                    first_rdy = i;
                    res_at    = data_result;
                    exc_at    = data_exception;
                end
            end
            @(posedge clk);
            #1;
            if ((first_rdy >= 0) && (i >= first_rdy + 2)) break;
        end
        mult_ready = 1'b0;
        div_ready  = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int          first, rcnt, ms, ds;
        logic [31:0] res, a0, b0;
        logic        exc, bz0;
        string       opname;
        opname = v.is_mult ? "MULT" : "DIV";
        issue(v.is_mult, !v.is_mult, v.a, v.b);
        run_unit(v.is_mult, v.ures, v.uflag, v.stale, v.d, first, rcnt, ms, ds, res, exc, bz0, a0, b0);
        check({tag, ".strobe_cycle"}, 64'(first), 64'(v.exp_lat));
        check({tag, ".strobe_count"}, 64'(rcnt), 64'd1);
        check({tag, ".result"}, 64'(res), 64'(v.exp_res));
        check({tag, ".exception"}, 64'(exc), 64'(v.exp_exc));
        check({tag, ".sel_start"}, 64'(v.is_mult ? ms : ds), 64'd1);
        check({tag, ".other_start"}, 64'(v.is_mult ? ds : ms), 64'd0);
        check({tag, ".busy_start"}, 64'(bz0), 64'd1);
        check({tag, ".op_a"}, 64'(a0), 64'(v.a));
        check({tag, ".op_b"}, 64'(b0), 64'(v.b));
        check({tag, ".result_hold"}, 64'(data_result), 64'(v.exp_res));
        check({tag, ".idle_after"}, 64'(busy), 64'd0);
        $display("%s %s a=%08h b=%08h -> result=%08h exc=%0d strobe@%0d (want %08h/%0d@%0d)",
                 tag, opname, v.a, v.b, res, exc, first, v.exp_res, v.exp_exc, v.exp_lat);
    endtask

    initial begin
        int          first, rcnt, ms, ds, win_rdy, win_ms, win_ds, bcnt;
        logic [31:0] res, a0, b0;
        logic        exc, bz0, rdy_at6;
        logic [31:0] res_at6;
        vec_t        v;
        bit          to;
        logic [63:0] prod;

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        mult_result   = '0;
        mult_ready    = 1'b0;
        mult_ovf      = 1'b0;
        div_quot      = '0;
        div_ready     = 1'b0;
        div_div0      = 1'b0;

        //                 mult  a             b             ures          flg stale d   exp_res       exc lat
        vecs[0] = '{1'b0, 32'd100,      32'd7,        32'd14,       1'b0, -1, 33, 32'd14,       1'b0, 34};
        vecs[1] = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, -1,  6, 32'hFFFFFFFF, 1'b1,  7};
        vecs[2] = '{1'b1, 32'd6,        32'd7,        32'd42,       1'b0, -1,  5, 32'd42,       1'b0,  6};
        vecs[3] = '{1'b1, 32'h00010000, 32'h00010000, 32'd0,        1'b1, -1,  8, 32'd0,        1'b1,  9};
        vecs[4] = '{1'b0, 32'd100,      32'd7,        32'd14,       1'b0,  1, 10, 32'd14,       1'b0, 11};
        vecs[5] = '{1'b0, 32'd9,        32'd3,        32'd3,        1'b0,  2, 20, 32'd3,        1'b0, 21};
        vecs[6] = '{1'b1, 32'd5,        32'd5,        32'd25,       1'b0,  3, 99, 32'd25,       1'b0,  4};
        vecs[7] = '{1'b1, 32'd2,        32'd3,        32'd6,        1'b0, -1,  0, 32'd6,        1'b0,  4};
        vecs[8] = '{1'b0, 32'd77,       32'd3,        32'd25,       1'b0, -1, 99, 32'd0,        1'b1, 42};
        vecs[9] = '{1'b1, 32'd7,        32'd8,        32'd56,       1'b0, -1, 40, 32'd56,       1'b0, 41};

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.data_result", 64'(data_result), 64'd0);
        check("reset.data_exception", 64'(data_exception), 64'd0);
        check("reset.data_resultRDY", 64'(data_resultRDY), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.op_a", 64'(op_a), 64'd0);
        check("reset.op_b", 64'(op_b), 64'd0);
        check("reset.mult_start", 64'(mult_start), 64'd0);
        check("reset.div_start", 64'(div_start), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int k = 0; k < 10; k++) begin
            run_op(vecs[k], $sformatf("vec%0d", k));
        end

        // Abort: DIV in flight, MULT 3*4 in BUSY cycle 10 while div_ready also rises.
        issue(1'b0, 1'b1, 32'd100, 32'd7);
        win_rdy = 0;
        win_ms  = 0;
        win_ds  = 0;
        for (int i = 0; i <= 10; i++) begin
            div_ready  = (i == 10);
            div_quot   = 32'd14;
            div_div0   = 1'b0;
            mult_ready = 1'b0;
            if (i == 10) begin
                ctrl_MULT     = 1'b1;
                data_operandA = 32'd3;
                data_operandB = 32'd4;
            end
            @(negedge clk);
            if (data_resultRDY) win_rdy++;
            if (mult_start) win_ms++;
            if (div_start) win_ds++;
            @(posedge clk);
            #1;
        end
        ctrl_MULT = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        run_unit(1'b1, 32'd12, 1'b0, -1, 5, first, rcnt, ms, ds, res, exc, bz0, a0, b0);
        check("abort.no_div_strobe", 64'(win_rdy), 64'd0);
        check("abort.div_start_once", 64'(win_ds), 64'd1);
        check("abort.no_mult_start_early", 64'(win_ms), 64'd0);
        check("abort.strobe_cycle", 64'(first), 64'd6);
        check("abort.strobe_count", 64'(rcnt), 64'd1);
        check("abort.result", 64'(res), 64'd12);
        check("abort.exception", 64'(exc), 64'd0);
        check("abort.mult_start", 64'(ms), 64'd1);
        check("abort.op_a", 64'(a0), 64'd3);
        check("abort.op_b", 64'(b0), 64'd4);
        $display("abort DIV 100/7 -> MULT 3*4 result=%08h exc=%0d strobe@%0d", res, exc, first);

        // Request in the DONE cycle: old result strobes, new op goes straight to START.
        issue(1'b1, 1'b0, 32'd6, 32'd7);
        win_rdy = 0;
        rdy_at6 = 1'b0;
        res_at6 = '0;
        for (int i = 0; i <= 6; i++) begin
            mult_ready  = (i == 5);
            mult_result = 32'd42;
            mult_ovf    = 1'b0;
            div_ready   = 1'b0;
            if (i == 6) begin
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd100;
                data_operandB = 32'd7;
            end
            @(negedge clk);
            if (i < 6 && data_resultRDY) win_rdy++;
            if (i == 6) begin
                rdy_at6 = data_resultRDY;
                res_at6 = data_result;
            end
            @(posedge clk);
            #1;
        end
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        run_unit(1'b0, 32'd14, 1'b0, -1, 33, first, rcnt, ms, ds, res, exc, bz0, a0, b0);
        check("done_req.no_early_strobe", 64'(win_rdy), 64'd0);
        check("done_req.old_strobe", 64'(rdy_at6), 64'd1);
        check("done_req.old_result", 64'(res_at6), 64'd42);
        check("done_req.busy_next", 64'(bz0), 64'd1);
        check("done_req.div_start", 64'(ds), 64'd1);
        check("done_req.new_strobe_cycle", 64'(first), 64'd34);
        check("done_req.new_result", 64'(res), 64'd14);
        $display("done_req MULT 6*7 then DIV 100/7 result=%08h strobe@%0d", res, first);

        // Both requests high: MULT wins, DIV is dropped.
        issue(1'b1, 1'b1, 32'd9, 32'd9);
        run_unit(1'b1, 32'd81, 1'b0, -1, 4, first, rcnt, ms, ds, res, exc, bz0, a0, b0);
        check("both.mult_start", 64'(ms), 64'd1);
        check("both.div_start", 64'(ds), 64'd0);
        check("both.strobe_cycle", 64'(first), 64'd5);
        check("both.strobe_count", 64'(rcnt), 64'd1);
        check("both.result", 64'(res), 64'd81);
        $display("both MULT+DIV 9,9 result=%08h strobe@%0d", res, first);

        // Asynchronous reset mid-BUSY.
        issue(1'b0, 1'b1, 32'd50, 32'd5);
        for (int i = 0; i < 6; i++) begin
            div_ready  = 1'b0;
            mult_ready = 1'b0;
            @(posedge clk);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.data_result", 64'(data_result), 64'd0);
        check("midrst.data_exception", 64'(data_exception), 64'd0);
        check("midrst.data_resultRDY", 64'(data_resultRDY), 64'd0);
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.op_a", 64'(op_a), 64'd0);
        check("midrst.op_b", 64'(op_b), 64'd0);
        check("midrst.mult_start", 64'(mult_start), 64'd0);
        check("midrst.div_start", 64'(div_start), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            div_ready  = 1'b1;
            mult_ready = 1'b1;
            @(negedge clk);
            if (data_resultRDY) rcnt++;
            if (busy) bcnt++;
            @(posedge clk);
            #1;
        end
        div_ready  = 1'b0;
        mult_ready = 1'b0;
        check("midrst.no_strobe_after", 64'(rcnt), 64'd0);
        check("midrst.stays_idle", 64'(bcnt), 64'd0);
        $display("midrst DIV 50/5 aborted by reset, strobes after=%0d", rcnt);

        // Randomized ops against the reference model.
        for (int k = 0; k < 40; k++) begin
            v.is_mult = 1'($urandom_range(0, 1));
            v.a       = $urandom;
            v.b       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            if ($urandom_range(0, 1) == 1) v.a = v.a & 32'h0000FFFF;
            if ($urandom_range(0, 1) == 1) v.b = v.b & 32'h0000FFFF;
            v.stale   = int'($urandom_range(0, 5)) - 1;
            v.d       = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 38));
            if (v.is_mult) begin
                prod    = 64'(v.a) * 64'(v.b);
                v.ures  = prod[31:0];
                v.uflag = (prod[63:32] != 32'd0);
            end else begin
                v.ures  = (v.b == 32'd0) ? 32'hFFFFFFFF : (v.a / v.b);
                v.uflag = (v.b == 32'd0);
            end
            v.exp_lat = model_strobe(v.stale, v.d, to);
            v.exp_res = to ? 32'd0 : v.ures;
            v.exp_exc = to ? 1'b1 : v.uflag;
            run_op(v, $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
